// File: rtl/cortina_pkg.sv
// Shared curtain-motor command encodings and sequencer state set; no timing, no flow control.
// The motor driver imports the same accion_t so both ends agree on the command bits.
package cortina_pkg;

  typedef enum logic [1:0] {
    PARAR = 2'b00,
    BAJAR = 2'b01,
    SUBIR = 2'b10
  } accion_t;

  typedef enum logic [2:0] {
    REPOSO,
    SUBIENDO,
    BAJANDO,
    PAUSA,
    FALLA
  } estado_t;

  // Counter width for a cycle-count parameter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Button conditioner: 2-flop sync, DEBOUNCE_CYCLES-stable filter, one-cycle press pulse.
// Pulse lands 2 + DEBOUNCE_CYCLES cycles after a steady raw press; no backpressure.
module antirrebote
  import cortina_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulso
);

  localparam int            DW     = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [1:0]    r_vld;
  logic          r_nivel;
  logic          r_nivel_d;
  logic          r_armado;
  logic [DW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_vld     <= 2'b00;
      r_nivel   <= 1'b0;
      r_nivel_d <= 1'b0;
      r_armado  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_vld     <= {r_vld[0], 1'b1};
      r_nivel_d <= r_nivel;
      if (r_sync2 == r_nivel) begin
        r_cnt <= '0;
      end else if (r_cnt == D_LAST) begin
        r_nivel <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
      // A button held through reset must be seen released before it may fire.
      if (r_vld[1] && !r_sync2 && !r_nivel)
        r_armado <= 1'b1;
    end
  end

  assign o_pulso = r_nivel & ~r_nivel_d & r_armado;

endmodule

// File: rtl/control_cortina.sv
// Curtain command sequencer: debounced buttons + limit switches -> registered SUBIR/BAJAR/PARAR.
// Limit to PARAR in 3 cycles, press to motion in 2+DEBOUNCE_CYCLES+1; no backpressure.
module control_cortina
  import cortina_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PAUSA_CYCLES    = 25_000_000,
  parameter int TIMEOUT_CYCLES  = 1_500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_subir,
  input  logic       btn_bajar,
  input  logic       fin_arriba,
  input  logic       fin_abajo,
  output logic [1:0] accion,
  output logic       en_movimiento,
  output logic       falla
);

  localparam int            TW     = cnt_w(TIMEOUT_CYCLES);
  localparam int            PW     = cnt_w(PAUSA_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PAUSA_CYCLES - 1);

  logic          w_press_sub;
  logic          w_press_baj;
  logic          r_arr_s1, r_arr_s2;
  logic          r_abj_s1, r_abj_s2;
  estado_t       r_estado, w_sig;
  logic          r_pend_subir;
  logic [TW-1:0] r_viaje;
  logic [PW-1:0] r_pausa;
  accion_t       w_accion, r_accion;
  logic          w_falla, r_falla, r_en_mov;

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_subir (
    .clk(clk), .rst(rst), .i_btn(btn_subir), .o_pulso(w_press_sub)
  );

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_bajar (
    .clk(clk), .rst(rst), .i_btn(btn_bajar), .o_pulso(w_press_baj)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_estado <= REPOSO;
    else     r_estado <= w_sig;
  end

  // Next state: limit beats timeout beats buttons
  always_comb begin
    w_sig = r_estado;
    case (r_estado)
      REPOSO: begin
        if (w_press_sub && !w_press_baj && !r_arr_s2)      w_sig = SUBIENDO;
        else if (w_press_baj && !w_press_sub && !r_abj_s2) w_sig = BAJANDO;
      end
      SUBIENDO: begin
        if (r_arr_s2)               w_sig = REPOSO;
        else if (r_viaje == T_LAST) w_sig = FALLA;
        else if (w_press_sub)       w_sig = REPOSO;
        else if (w_press_baj)       w_sig = PAUSA;
      end
      BAJANDO: begin
        if (r_abj_s2)               w_sig = REPOSO;
        else if (r_viaje == T_LAST) w_sig = FALLA;
        else if (w_press_baj)       w_sig = REPOSO;
        else if (w_press_sub)       w_sig = PAUSA;
      end
      PAUSA: begin
        if (w_press_sub || w_press_baj) w_sig = REPOSO;
        else if (r_pausa == P_LAST) begin
          if (r_pend_subir) w_sig = r_arr_s2 ? REPOSO : SUBIENDO;
          else              w_sig = r_abj_s2 ? REPOSO : BAJANDO;
        end
      end
      FALLA:   w_sig = FALLA;
      default: w_sig = REPOSO;
    endcase
  end

  // Outputs decoded from the next state so they register alongside the transition
  always_comb begin
    w_accion = PARAR;
    w_falla  = 1'b0;
    case (w_sig)
      SUBIENDO: w_accion = SUBIR;
      BAJANDO:  w_accion = BAJAR;
      FALLA:    w_falla  = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_arr_s1     <= 1'b0;
      r_arr_s2     <= 1'b0;
      r_abj_s1     <= 1'b0;
      r_abj_s2     <= 1'b0;
      r_pend_subir <= 1'b0;
      r_viaje      <= '0;
      r_pausa      <= '0;
      r_accion     <= PARAR;
      r_falla      <= 1'b0;
      r_en_mov     <= 1'b0;
    end else begin
      r_arr_s1 <= fin_arriba;
      r_arr_s2 <= r_arr_s1;
      r_abj_s1 <= fin_abajo;
      r_abj_s2 <= r_abj_s1;

      if (w_sig != r_estado && (w_sig == SUBIENDO || w_sig == BAJANDO))
        r_viaje <= '0;
      else if ((r_estado == SUBIENDO || r_estado == BAJANDO) && r_viaje != T_LAST)
        r_viaje <= r_viaje + TW'(1);

      if (w_sig == PAUSA && r_estado != PAUSA)
        r_pausa <= '0;
      else if (r_estado == PAUSA && r_pausa != P_LAST)
        r_pausa <= r_pausa + PW'(1);

      if (r_estado == SUBIENDO && w_sig == PAUSA)     r_pend_subir <= 1'b0;
      else if (r_estado == BAJANDO && w_sig == PAUSA) r_pend_subir <= 1'b1;

      r_accion <= w_accion;
      r_falla  <= w_falla;
      r_en_mov <= (w_accion != PARAR);
    end
  end

  assign accion        = r_accion;
  assign en_movimiento = r_en_mov;
  assign falla         = r_falla;

endmodule

// File: tb/tb_control_cortina.sv
// Bench for control_cortina: scoreboard of expected {falla,accion} changes with cycle stamps.
module tb_control_cortina;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_subir = 1'b0;
  logic       btn_bajar = 1'b0;
  logic       fin_arriba = 1'b0;
  logic       fin_abajo = 1'b0;
  logic [1:0] accion;
  logic       en_movimiento;
  logic       falla;

  control_cortina #(
    .DEBOUNCE_CYCLES(4),
    .PAUSA_CYCLES(8),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_subir(btn_subir), .btn_bajar(btn_bajar),
    .fin_arriba(fin_arriba), .fin_abajo(fin_abajo),
    .accion(accion), .en_movimiento(en_movimiento), .falla(falla)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] v;
    int         cyc;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_mis = 0;
  logic       mon_en = 1'b0;
  logic [2:0] last_v = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input string tag, input logic f, input logic [1:0] a, input int c);
    exp_t e;
    e.v   = {f, a};
    e.cyc = c;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every output change must match the head of the scoreboard, at the predicted cycle.
  always @(negedge clk) begin
    logic [2:0] cur;
    exp_t       e;
    if (mon_en) begin
      cur = {falla, accion};
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        e = sb.pop_front();
        chk({e.tag, "_late"}, cyc, e.cyc);
      end
      if (cur != last_v) begin
        if (last_v[1:0] != 2'b00 && cur[1:0] != 2'b00)
          chk("direct_reversal", cur[1:0], 2'b00);
        if (sb.size() == 0) begin
          chk("unexpected_change", cur, last_v);
        end else begin
          e = sb.pop_front();
          chk({e.tag, "_val"}, cur, e.v);
          chk({e.tag, "_cyc"}, cyc, e.cyc);
          chk({e.tag, "_en"}, en_movimiento, (e.v[1:0] != 2'b00));
        end
        last_v = cur;
      end
    end
  end

  initial begin
    int c;
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_accion", accion, 2'b00);
    chk("rst_en", en_movimiento, 1'b0);
    chk("rst_falla", falla, 1'b0);
    mon_en = 1'b1;
    step(5);

    // Raise then stop at top
    c = cyc; btn_subir = 1'b1; push("up_start", 1'b0, 2'b10, c + 7);
    step(10); btn_subir = 1'b0; step(20);
    c = cyc; fin_arriba = 1'b1; push("top_stop", 1'b0, 2'b00, c + 3);
    step(10); fin_arriba = 1'b0; step(10);

    // Bounce rejection
    for (int i = 0; i < 10; i++) begin
      btn_bajar = ~btn_bajar;
      step(2);
    end
    step(10);
    chk("bounce_accion", accion, 2'b00);
    chk("bounce_en", en_movimiento, 1'b0);

    // Reversal down -> pause -> up
    c = cyc; btn_bajar = 1'b1; push("rev_down", 1'b0, 2'b01, c + 7);
    step(10); btn_bajar = 1'b0; step(10);
    c = cyc; btn_subir = 1'b1;
    push("rev_pause", 1'b0, 2'b00, c + 7);
    push("rev_up", 1'b0, 2'b10, c + 15);
    step(10); btn_subir = 1'b0; step(15);
    c = cyc; fin_arriba = 1'b1; push("rev_top", 1'b0, 2'b00, c + 3);
    step(10); fin_arriba = 1'b0; step(5);

    // Travel timeout, sticky fault
    c = cyc; btn_bajar = 1'b1;
    push("to_down", 1'b0, 2'b01, c + 7);
    push("to_fault", 1'b1, 2'b00, c + 57);
    step(10); btn_bajar = 1'b0; step(55);
    btn_subir = 1'b1; step(10); btn_subir = 1'b0; step(10);
    btn_bajar = 1'b1; step(10); btn_bajar = 1'b0; step(10);
    chk("fault_sticky", falla, 1'b1);
    chk("fault_accion", accion, 2'b00);
    c = cyc; rst = 1'b1; push("fault_rst", 1'b0, 2'b00, c + 1);
    step(1); rst = 1'b0; step(5);
    chk("post_rst_falla", falla, 1'b0);

    // Blocked start and conflicting presses
    fin_abajo = 1'b1; step(3);
    btn_bajar = 1'b1; step(10); btn_bajar = 1'b0; step(10);
    chk("blocked_accion", accion, 2'b00);
    fin_abajo = 1'b0; step(5);
    btn_subir = 1'b1; btn_bajar = 1'b1; step(10);
    btn_subir = 1'b0; btn_bajar = 1'b0; step(10);
    chk("both_accion", accion, 2'b00);
    chk("both_en", en_movimiento, 1'b0);

    // Reset mid-travel with the button still held
    c = cyc; btn_subir = 1'b1; push("mid_up", 1'b0, 2'b10, c + 7);
    step(15);
    c = cyc; rst = 1'b1; push("mid_rst", 1'b0, 2'b00, c + 1);
    step(1); rst = 1'b0;
    chk("mid_rst_accion", accion, 2'b00);
    chk("mid_rst_en", en_movimiento, 1'b0);
    chk("mid_rst_falla", falla, 1'b0);
    step(20);
    chk("held_no_move", accion, 2'b00);
    btn_subir = 1'b0; step(10);
    c = cyc; btn_subir = 1'b1; push("repress_up", 1'b0, 2'b10, c + 7);
    step(10); btn_subir = 1'b0;
    c = cyc; fin_arriba = 1'b1; push("final_top", 1'b0, 2'b00, c + 3);
    step(10); fin_arriba = 1'b0; step(5);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/control_cortina.md
# control_cortina

Command sequencer that drives the curtain motor driver's `accion` input. It turns raw wall-button presses and limit-switch levels into a registered SUBIR/BAJAR/PARAR command. It enforces a dead time before reversals and a travel timeout, and stops the motor at the limit switches. It sits between the board I/O pins and the motor driver, in the same clock domain.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: stable cycles required before a button level is accepted (20 ms at 50 MHz).
- `PAUSA_CYCLES`, 25_000_000: dead time between reversing directions.
- `TIMEOUT_CYCLES`, 1_500_000_000: maximum cycles in one travel before a fault is raised.
- `clk` in 1: system clock. Single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_subir` in 1: raw up button, active-high, asynchronous.
- `btn_bajar` in 1: raw down button, active-high, asynchronous.
- `fin_arriba` in 1: raw top limit switch, active-high, asynchronous.
- `fin_abajo` in 1: raw bottom limit switch, active-high, asynchronous.
- `accion` out 2: motor command. SUBIR=2'b10, BAJAR=2'b01, PARAR=2'b00.
- `en_movimiento` out 1: high while `accion` is not PARAR.
- `falla` out 1: sticky travel-timeout fault.

## Operation
- **Input conditioning:** all four inputs pass through a 2-flop synchronizer.
- **Button debounce:** a button's debounced level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles.
- **Press events:** a press event is a single-cycle pulse on the debounced rising edge.
- **Limit switches:** used synchronized but not debounced.
- **FSM states:** REPOSO, SUBIENDO, BAJANDO, PAUSA, FALLA. Reset enters REPOSO.
- **REPOSO:**
  - Up press with top limit low → SUBIENDO.
  - Down press with bottom limit low → BAJANDO.
  - A press toward an active limit is ignored.
  - Both presses in the same cycle are ignored.
- **SUBIENDO / BAJANDO:**
  - Target limit high → REPOSO.
  - Same-direction press → REPOSO.
  - Both presses in the same cycle → REPOSO.
  - Opposite press → PAUSA, latching the opposite direction as pending.
  - Travel counter reaches TIMEOUT_CYCLES-1 → FALLA.
- **PAUSA:**
  - `accion` is PARAR.
  - Any press → REPOSO (cancel).
  - After PAUSA_CYCLES in state: move to the pending direction, or to REPOSO if that direction's limit is high.
- **FALLA:** `accion`=PARAR and `falla`=1. Only `rst` exits this state.
- **Priority within one cycle:** limit > timeout > button events.
- **Counters:**
  - The travel counter clears on every entry to SUBIENDO/BAJANDO.
  - The pause counter clears on entry to PAUSA.
  - Widths are $clog2 of the parameter. The counters saturate and never wrap.

## Timing
- **Reset values:** `accion`=2'b00, `en_movimiento`=0, `falla`=0, debounced levels=0, counters=0.
- `accion`, `en_movimiento` and `falla` are registered. Each changes in the cycle after the FSM transition.
- **Press to `accion`:** a raw press held steady gives `accion` after 2 + DEBOUNCE_CYCLES + 1 cycles.
- **Limit to stop:** a raw limit rising gives `accion`=PARAR after 3 cycles (2 sync + 1 register).
- **Reversal:** `accion` is PARAR for exactly PAUSA_CYCLES cycles between the two directions. It never switches directly from SUBIR to BAJAR or from BAJAR to SUBIR.
- **Timeout:** `falla` and `accion`=PARAR appear the cycle after the TIMEOUT_CYCLES-th moving cycle.
- **Reset mid-travel:** `accion`=PARAR in the cycle after `rst` is sampled high. A button still held after reset produces no event until it is released and pressed again.

## Structure
- Package `cortina_pkg` holds:
  - the `accion` encodings SUBIR/BAJAR/PARAR;
  - the state enum for REPOSO/SUBIENDO/BAJANDO/PAUSA/FALLA.
- The motor driver uses the same encodings from this package.
- Sub-module `antirrebote` contains the synchronizer, debounce counter and rising-edge pulse. It is instantiated once per button.
- The limit-switch synchronizers stay inline in the top module.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, PAUSA_CYCLES=8, TIMEOUT_CYCLES=50.
- **Raise then stop at top:** pulse `btn_subir` high for 10 cycles, then assert `fin_arriba` 20 cycles later. Required: `accion`=2'b10 exactly 7 cycles after the button rises, and 2'b00 exactly 3 cycles after `fin_arriba` rises.
- **Bounce rejection:** toggle `btn_bajar` every 2 cycles for 20 cycles. Required: `accion` stays 2'b00 and `en_movimiento`=0.
- **Reversal:** while BAJANDO, press `btn_subir`. Required: `accion`=2'b00 for exactly 8 cycles, then 2'b10. 2'b01 is never followed directly by 2'b10.
- **Timeout:** press `btn_bajar` with no limit switch asserted. Required: `falla`=1 and `accion`=2'b00 fifty cycles after motion starts. Further presses are ignored until `rst`.
- **Blocked start and conflicting presses:** hold `fin_abajo` high and press `btn_bajar`; separately, press both buttons in the same cycle from REPOSO. Required: `accion` stays 2'b00 in both cases.
- **Reset mid-travel:** assert `rst` for 1 cycle during SUBIENDO. Required: `accion`=2'b00 in the next cycle and all outputs at their reset values.
